huffman_bit_packer: RTL and testbench
=====================================

HUFFMAN_BIT_PACKER -- requirements
Module: huffman_bit_packer

Interface
REQ-001 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-002 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-003 SHALL have port code_valid, input, 1 bit, one-cycle strobe marking HC1..HC6/M1..M6 valid.
REQ-004 SHALL have ports HC1..HC6, input, 8 bits each, code value for symbols 1..6, right-aligned.
REQ-005 SHALL have ports M1..M6, input, 8 bits each, code mask for symbols 1..6; contiguous ones from bit 0; code length = number of ones.
REQ-006 SHALL have ports sym_valid/sym_ready, input/output, 1 bit each, symbol handshake; transfer when both are high.
REQ-007 SHALL have ports sym_data (input, 8 bits, gray value 1..6) and sym_last (input, 1 bit, final symbol).
REQ-008 SHALL have ports byte_valid/byte_ready, output/input, 1 bit each, byte handshake.
REQ-009 SHALL have ports byte_data (output, 8 bits, packed bits, MSB = earliest bit) and byte_last (output, 1 bit, final byte).
REQ-010 SHALL have port err_sym, output, 1 bit, one-cycle pulse when an invalid symbol is dropped.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-012 SHALL, in IDLE on code_valid, latch all 12 table bytes and go to RUN the next cycle; code_valid outside IDLE is ignored.
REQ-013 SHALL hold a 16-bit bit accumulator and a 5-bit fill count (0..16).
REQ-014 SHALL drive sym_ready = (state==RUN) && (fill<=8).
REQ-015 SHALL, on an accepted symbol s in 1..6 with nonzero M_s, append HC_s[len-1:0] MSB-first behind the existing bits; fill += len.
REQ-016 SHALL drop accepted symbols 0, >6, or with M_s==0: no bits appended, err_sym pulses the following cycle, sym_last still honoured.
REQ-017 SHALL assert byte_valid in RUN when fill>=8, presenting the oldest 8 bits; a transfer removes them and fill -= 8.
REQ-018 SHALL permit symbol acceptance and byte transfer in the same cycle, both applied to the fill count.
REQ-019 SHALL keep byte_data and byte_last stable while byte_valid=1 and byte_ready=0.
REQ-020 SHALL, after sym_last is accepted, go to FLUSH next cycle and accept no further symbols.
REQ-021 SHALL, in FLUSH, emit full bytes while fill>8, then emit the residual 1..8 bits left-aligned and zero-padded with byte_last=1.
REQ-022 SHALL, on transfer of the byte_last byte, go to DONE, then return to IDLE next cycle; the table must be reloaded.
REQ-023 SHALL, if sym_last is accepted with fill==0 after a dropped symbol, emit byte 8'h00 with byte_last=1.
REQ-024 SHALL keep worst-case latency from symbol acceptance to its byte's byte_valid at 1 cycle.

Reset
REQ-025 SHALL, on reset, set state=IDLE, fill=0, accumulator=0, table=0, sym_ready=0, byte_valid=0, byte_data=0, byte_last=0, err_sym=0.
REQ-026 SHALL, on reset mid-operation, discard all buffered bits with no partial byte output.

Configuration
REQ-027 SHALL, when HUFF_PACK_STATS_EN is defined, add 16-bit outputs sym_count and byte_count, which count accepted valid symbols and transferred bytes, clear on reset and on IDLE->RUN, and saturate at 16'hFFFF.
REQ-028 SHALL, without HUFF_PACK_STATS_EN, omit those ports and counters and leave all other behaviour identical.

Structure
REQ-029 SHALL take the FSM state enum, the symbol count (6), and the code width (8) from shared package huffman_pkg.
REQ-030 SHALL implement mask-to-length conversion (8-bit mask to 4-bit length) as sub-module huff_mask_len.

Verification
REQ-031 SHALL cover: table {S1: HC=00 M=01; S2: HC=02 M=03; S3: HC=06 M=07}, symbols 1,2,3,1(last) -> one byte 8'h58 with byte_last=1.
REQ-032 SHALL cover: eight symbol-1 with the last on the 8th -> single byte 8'h00 with byte_last=1 and no extra byte.
REQ-033 SHALL cover: byte_ready held low 5 cycles with fill>=8 -> sym_ready falls once fill>8, and byte_data stays stable.
REQ-034 SHALL cover: symbol 7 injected mid-stream -> err_sym pulses once and the output equals the stream with that symbol removed.
REQ-035 SHALL cover: reset asserted while fill=5 in RUN -> next cycle all outputs are 0, state=IDLE, and no byte is emitted.
REQ-036 SHALL cover: HUFF_PACK_STATS_EN build running the scenario in REQ-031 -> sym_count=4, byte_count=1.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman bit packer: FSM states and table geometry.
package huffman_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_SYM = 6;
    localparam int CODE_W  = 8;
    localparam int LEN_W   = 4;
    localparam int ACC_W   = 16;
endpackage

// File: rtl/huff_mask_len.sv
// Converts a right-aligned code mask into its code length (number of ones).
module huff_mask_len
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0] mask,
    output logic [LEN_W-1:0]  len
);
    always_comb begin
        len = '0;
        for (int i = 0; i < CODE_W; i++) begin
            len = len + LEN_W'(mask[i]);
        end
    end
endmodule

// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codes for symbols 1..6 into MSB-first bytes.
// Define HUFF_PACK_STATS_EN to add saturating symbol/byte counters.
module huffman_bit_packer
    import huffman_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [7:0]  HC1,
    input  logic [7:0]  HC2,
    input  logic [7:0]  HC3,
    input  logic [7:0]  HC4,
    input  logic [7:0]  HC5,
    input  logic [7:0]  HC6,
    input  logic [7:0]  M1,
    input  logic [7:0]  M2,
    input  logic [7:0]  M3,
    input  logic [7:0]  M4,
    input  logic [7:0]  M5,
    input  logic [7:0]  M6,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [7:0]  sym_data,
    input  logic        sym_last,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    output logic        err_sym
`ifdef HUFF_PACK_STATS_EN
    ,
    output logic [15:0] sym_count,
    output logic [15:0] byte_count
`endif
);
    state_t                            state_q, state_d;
    logic [ACC_W-1:0]                  acc_q, acc_d;
    logic [4:0]                        fill_q, fill_d;
    logic [NUM_SYM-1:0][CODE_W-1:0]    hc_q, hc_d, mask_q, mask_d;
    logic [NUM_SYM-1:0][CODE_W-1:0]    hc_in, mask_in;
    logic [NUM_SYM-1:0][LEN_W-1:0]     len_w;
    logic                              sym_ready_q, sym_ready_d;
    logic                              byte_valid_q, byte_valid_d;
    logic [7:0]                        byte_data_q, byte_data_d;
    logic                              byte_last_q, byte_last_d;
    logic                              err_sym_q, err_sym_d;
    logic                              sym_acc, byte_xfer, sym_ok;
    logic [CODE_W-1:0]                 sel_code;
    logic [LEN_W-1:0]                  sel_len;

    assign hc_in   = {HC6, HC5, HC4, HC3, HC2, HC1};
    assign mask_in = {M6, M5, M4, M3, M2, M1};

    for (genvar g = 0; g < NUM_SYM; g++) begin : g_len
        huff_mask_len u_len (.mask(mask_q[g]), .len(len_w[g]));
    end

    assign sym_acc   = sym_valid && sym_ready_q;
    assign byte_xfer = byte_valid_q && byte_ready;

    always_comb begin
        sel_code = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (sym_data == 8'(i + 1)) begin
                sel_code = hc_q[i] & mask_q[i];
                sel_len  = len_w[i];
            end
        end
        sym_ok = (sel_len != '0);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        hc_d      = hc_q;
        mask_d    = mask_q;
        err_sym_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (code_valid) begin
                    hc_d    = hc_in;
                    mask_d  = mask_in;
                    acc_d   = '0;
                    fill_d  = '0;
                    state_d = RUN;
                end
            end
            RUN, FLUSH: begin
                // Drain first so a same-cycle symbol lands behind the remaining bits.
                if (byte_xfer) begin
                    if (byte_last_q) begin
                        acc_d   = '0;
                        fill_d  = '0;
                        state_d = DONE;
                    end else begin
                        acc_d  = acc_q << 8;
                        fill_d = fill_q - 5'd8;
                    end
                end
                if (sym_acc) begin
                    if (sym_ok) begin
                        acc_d  = acc_d | ((ACC_W'(sel_code) << (5'd16 - 5'(sel_len))) >> fill_d);
                        fill_d = fill_d + 5'(sel_len);
                    end else begin
                        err_sym_d = 1'b1;
                    end
                    if (sym_last) state_d = FLUSH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sym_ready_d  = (state_d == RUN) && (fill_d <= 5'd8);
        byte_valid_d = ((state_d == RUN) && (fill_d >= 5'd8)) || (state_d == FLUSH);
        byte_data_d  = acc_d[ACC_W-1 -: 8];
        byte_last_d  = (state_d == FLUSH) && (fill_d <= 5'd8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            fill_q       <= '0;
            hc_q         <= '0;
            mask_q       <= '0;
            sym_ready_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_last_q  <= 1'b0;
            err_sym_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            hc_q         <= hc_d;
            mask_q       <= mask_d;
            sym_ready_q  <= sym_ready_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_last_q  <= byte_last_d;
            err_sym_q    <= err_sym_d;
        end
    end

    assign sym_ready  = sym_ready_q;
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign byte_last  = byte_last_q;
    assign err_sym    = err_sym_q;

`ifdef HUFF_PACK_STATS_EN
    logic [15:0] sym_cnt_q, sym_cnt_d, byte_cnt_q, byte_cnt_d;

    always_comb begin
        sym_cnt_d  = sym_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (state_q == IDLE && code_valid) begin
            sym_cnt_d  = '0;
            byte_cnt_d = '0;
        end else begin
            if (sym_acc && sym_ok && sym_cnt_q != 16'hFFFF) sym_cnt_d = sym_cnt_q + 16'd1;
            if (byte_xfer && byte_cnt_q != 16'hFFFF)         byte_cnt_d = byte_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_cnt_q  <= '0;
            byte_cnt_q <= '0;
        end else begin
            sym_cnt_q  <= sym_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign sym_count  = sym_cnt_q;
    assign byte_count = byte_cnt_q;
`endif
endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer with a bit-level scoreboard of expected bytes.
module tb_huffman_bit_packer;
    import huffman_pkg::*;

    logic       clk, reset, code_valid;
    logic [7:0] hc [1:6];
    logic [7:0] m  [1:6];
    logic       sym_valid, sym_ready, sym_last;
    logic [7:0] sym_data;
    logic       byte_valid, byte_ready, byte_last, err_sym;
    logic [7:0] byte_data;
`ifdef HUFF_PACK_STATS_EN
    logic [15:0] sym_count, byte_count;
`endif

    huffman_bit_packer dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(hc[1]), .HC2(hc[2]), .HC3(hc[3]), .HC4(hc[4]), .HC5(hc[5]), .HC6(hc[6]),
        .M1(m[1]), .M2(m[2]), .M3(m[3]), .M4(m[4]), .M5(m[5]), .M6(m[6]),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .byte_last(byte_last), .err_sym(err_sym)
`ifdef HUFF_PACK_STATS_EN
        , .sym_count(sym_count), .byte_count(byte_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit         bitq[$];
    logic [8:0] expq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         err_cnt = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_byte(input bit last);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bitq.size() > 0) b = {b[6:0], bitq.pop_front()};
            else                 b = {b[6:0], 1'b0};
        end
        expq.push_back({last, b});
    endtask

    // Reference packer: appends code bits, emits full bytes, flushes the tail on last.
    task automatic model_sym(input logic [7:0] s, input bit last);
        int si  = int'(s);
        int len = 0;
        if (si >= 1 && si <= 6)
            for (int i = 0; i < 8; i++) len += int'(m[si][i]);
        for (int i = len - 1; i >= 0; i--) bitq.push_back(hc[si][i]);
        if (!last) begin
            while (bitq.size() >= 8) take_byte(1'b0);
        end else begin
            while (bitq.size() > 8) take_byte(1'b0);
            take_byte(1'b1);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (err_sym) err_cnt++;
            if (byte_valid && byte_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    assert (expq.size() != 0) else begin
                        n_bad++;
                        $error("FAIL extra_byte: got %0h last %0b expected none", byte_data, byte_last);
                    end
                end else begin
                    logic [8:0] e;
                    e = expq.pop_front();
                    check("byte_out", {7'd0, byte_last, byte_data}, {7'd0, e});
                end
            end
        end
    end

    task automatic set_table(input int sel);
        for (int i = 1; i <= 6; i++) begin hc[i] = 8'h00; m[i] = 8'h00; end
        if (sel == 0) begin
            hc[1] = 8'h00; m[1] = 8'h01;
            hc[2] = 8'h02; m[2] = 8'h03;
            hc[3] = 8'h06; m[3] = 8'h07;
        end else begin
            hc[4] = 8'hA5; m[4] = 8'hFF;
            hc[5] = 8'h03; m[5] = 8'h0F;
            hc[6] = 8'h01; m[6] = 8'h1F;
        end
        @(posedge clk); #1 code_valid = 1'b1;
        @(posedge clk); #1 code_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] s, input bit last);
        int n = 0;
        model_sym(s, last);
        sym_valid = 1'b1; sym_data = s; sym_last = last;
        @(negedge clk);
        while (!sym_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) check("sym_ready_timeout", 16'(n), 16'd0);
        @(posedge clk); #1;
        sym_valid = 1'b0; sym_data = 8'h00; sym_last = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((expq.size() != 0 || byte_valid) && n < 300) begin @(negedge clk); n++; end
        check({tag, "_drain_timeout"}, 16'(n >= 300), 16'd0);
        repeat (3) @(negedge clk);
        check({tag, "_idle"}, 16'(dut.state_q), 16'(IDLE));
    endtask

    initial begin
        int e0;
        logic [7:0] held;
        reset = 1'b1; code_valid = 1'b0; sym_valid = 1'b0; sym_data = 8'h00;
        sym_last = 1'b0; byte_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin hc[i] = 8'h00; m[i] = 8'h00; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sym_ready", 16'(sym_ready), 16'd0);
        check("rst_byte_valid", 16'(byte_valid), 16'd0);
        check("rst_byte_data", 16'(byte_data), 16'd0);
        check("rst_byte_last", 16'(byte_last), 16'd0);
        check("rst_err_sym", 16'(err_sym), 16'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Basic three-code table, single 7-bit output byte 0x58.
        set_table(0);
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd1, 1'b1);
        drain("basic");
`ifdef HUFF_PACK_STATS_EN
        check("stat_sym_count", sym_count, 16'd4);
        check("stat_byte_count", byte_count, 16'd1);
`endif

        // Exactly eight bits on the last symbol: one byte, flagged last.
        set_table(0);
        for (int i = 0; i < 8; i++) send(8'd1, i == 7);
        drain("eight_ones");

        // Full-width and mixed codes spanning several bytes.
        set_table(1);
        send(8'd4, 1'b0); send(8'd5, 1'b0); send(8'd4, 1'b0);
        send(8'd6, 1'b0); send(8'd4, 1'b0); send(8'd5, 1'b1);
        drain("mixed");

        // Output backpressure: fill reaches 9, sym_ready drops, byte holds.
        set_table(0);
        byte_ready = 1'b0;
        send(8'd3, 1'b0); send(8'd3, 1'b0); send(8'd3, 1'b0);
        @(negedge clk);
        check("stall_sym_ready", 16'(sym_ready), 16'd0);
        check("stall_byte_valid", 16'(byte_valid), 16'd1);
        check("stall_byte_data", 16'(byte_data), 16'h00DB);
        held = byte_data;
        repeat (5) begin
            @(negedge clk);
            check("stall_stable", 16'(byte_data), 16'(held));
            check("stall_ready_low", 16'(sym_ready), 16'd0);
        end
        @(posedge clk); #1 byte_ready = 1'b1;
        send(8'd3, 1'b1);
        drain("stall");

        // Invalid symbol mid-stream is dropped with one error pulse.
        set_table(0);
        e0 = err_cnt;
        send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd7, 1'b0);
        send(8'd3, 1'b0); send(8'd1, 1'b1);
        drain("bad_sym");
        check("bad_sym_err_cnt", 16'(err_cnt - e0), 16'd1);

        // Dropped last symbol with nothing buffered yields a lone 0x00 last byte.
        set_table(0);
        e0 = err_cnt;
        send(8'd4, 1'b1);
        drain("empty_last");
        check("empty_last_err_cnt", 16'(err_cnt - e0), 16'd1);

        // Reset with five bits buffered discards them.
        set_table(0);
        send(8'd3, 1'b0); send(8'd2, 1'b0);
        check("pre_rst_fill", 16'(dut.fill_q), 16'd5);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bitq.delete(); expq.delete();
        @(negedge clk);
        check("midrst_state", 16'(dut.state_q), 16'(IDLE));
        check("midrst_sym_ready", 16'(sym_ready), 16'd0);
        check("midrst_byte_valid", 16'(byte_valid), 16'd0);
        check("midrst_byte_data", 16'(byte_data), 16'd0);
        check("midrst_byte_last", 16'(byte_last), 16'd0);
        check("midrst_err_sym", 16'(err_sym), 16'd0);
        repeat (10) @(negedge clk);
        check("midrst_no_byte", 16'(byte_valid), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
